// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks the register file read port from address 0 to NUM_REGS-1
// and streams each word as an (address, data) beat over a valid/ready handshake.
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [ADDR_W-1:0] dump_addr_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] w_rd_addr_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic              r_last;
    logic              w_last_nxt;
    logic              r_busy;
    logic              r_done;
    logic              w_done_nxt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_rd_addr <= '0;
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_valid   <= w_valid_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_last    <= w_last_nxt;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_rd_addr_nxt = r_rd_addr;
        w_valid_nxt   = r_valid;
        w_addr_nxt    = r_addr;
        w_data_nxt    = r_data;
        w_last_nxt    = r_last;
        w_done_nxt    = r_done;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_idx_nxt     = '0;
                    w_rd_addr_nxt = '0;
                    w_state_nxt   = READ;
                end
            end
            READ: begin
                w_data_nxt  = rd_data_i;
                w_addr_nxt  = r_idx;
                w_last_nxt  = (r_idx == LAST_IDX);
                w_valid_nxt = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                // Beat outputs are held by the defaults until the handshake.
                if (r_valid && dump_ready_i) begin
                    w_valid_nxt = 1'b0;
                    if (r_idx != LAST_IDX) begin
                        w_idx_nxt     = r_idx + ADDR_W'(1);
                        w_rd_addr_nxt = r_idx + ADDR_W'(1);
                        w_state_nxt   = READ;
                    end else begin
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_done_nxt    = 1'b0;
                w_rd_addr_nxt = '0;
                w_state_nxt   = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign rd_addr_o    = r_rd_addr;
    assign dump_valid_o = r_valid;
    assign dump_addr_o  = r_addr;
    assign dump_data_o  = r_data;
    assign dump_last_o  = r_last;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: expected beats are queued at each start and
// popped by an independent monitor on every accepted beat.
module tb_reg_dump_reader;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_i;
    logic              dump_valid_o;
    logic              dump_ready_i = 1'b1;
    logic [ADDR_W-1:0] dump_addr_o;
    logic [DATA_W-1:0] dump_data_o;
    logic              dump_last_o;
    logic              busy_o;
    logic              done_o;

    logic [DATA_W-1:0] regs [NUM_REGS];
    beat_t             sb [$];
    int                checks = 0;
    int                failures = 0;

    assign rd_data_i = regs[rd_addr_o];

    reg_dump_reader #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .rd_addr_o    (rd_addr_o),
        .rd_data_i    (rd_data_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_addr_o  (dump_addr_o),
        .dump_data_o  (dump_data_o),
        .dump_last_o  (dump_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".rd_addr"}, DATA_W'(rd_addr_o), '0);
        chk({name, ".valid"}, DATA_W'(dump_valid_o), '0);
        chk({name, ".addr"}, DATA_W'(dump_addr_o), '0);
        chk({name, ".data"}, dump_data_o, '0);
        chk({name, ".last"}, DATA_W'(dump_last_o), '0);
        chk({name, ".busy"}, DATA_W'(busy_o), '0);
        chk({name, ".done"}, DATA_W'(done_o), '0);
    endtask

    // Monitor: one pop per accepted beat.
    always @(negedge clk_i) begin
        if (!rst_i && dump_valid_o && dump_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beat_unexpected: got addr %0d with empty scoreboard", dump_addr_o);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat.addr", DATA_W'(dump_addr_o), DATA_W'(e.addr));
                chk("beat.data", dump_data_o, e.data);
                chk("beat.last", DATA_W'(dump_last_o), DATA_W'(e.last));
            end
        end
    end

    // mode: 0 plain, 1 backpressure on beat 5, 2 start while busy,
    // 3 plain then chain next start with R7 rewritten, 4 reset while beat 10 valid.
    task automatic run_dump(input int mode);
        int exp_done;
        exp_done = (mode == 1) ? 67 : 64;
        for (int i = 0; i < NUM_REGS; i++) begin
            beat_t b;
            b.addr = ADDR_W'(i);
            b.data = regs[i];
            b.last = (i == NUM_REGS - 1);
            sb.push_back(b);
        end
        if (!start_i) begin
            @(negedge clk_i);
            start_i = 1'b1;
        end
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int n = 1; n <= exp_done + 2; n++) begin
            @(posedge clk_i);
            #1;
            if (mode == 4 && n == 21) begin
                chk("rst_mid.pre_valid", DATA_W'(dump_valid_o), 1);
                chk("rst_mid.pre_addr", DATA_W'(dump_addr_o), 10);
                #2;
                rst_i = 1'b1;
                #1;
                chk_all_zero("rst_mid");
                sb.delete();
                @(negedge clk_i);
                rst_i = 1'b0;
                return;
            end
            chk("done_timing", DATA_W'(done_o), DATA_W'(n == exp_done));
            chk("busy_timing", DATA_W'(busy_o), DATA_W'(n <= exp_done));
            if (mode == 1) begin
                if (n >= 11 && n <= 14) begin
                    chk("bp.valid", DATA_W'(dump_valid_o), 1);
                    chk("bp.addr", DATA_W'(dump_addr_o), 5);
                    chk("bp.data", dump_data_o, 21);
                end
                if (n == 11) dump_ready_i = 1'b0;
                if (n == 14) dump_ready_i = 1'b1;
            end
            if (mode == 2) start_i = (n == 7 || n == 63 || n == 64);
            if (mode == 3 && n == exp_done + 1) begin
                chk("chain.sb_empty", DATA_W'(sb.size()), 0);
                regs[7] = 32'hDEADBEEF;
                start_i = 1'b1;
                return;
            end
        end
        chk("sb_empty", DATA_W'(sb.size()), 0);
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(4 * i + 1);
        regs[29] = 32'd128;

        // Asynchronous reset mid-cycle, start held high.
        #2;
        start_i = 1'b1;
        rst_i   = 1'b1;
        #1;
        chk_all_zero("reset_async");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        rst_i   = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk_i);
            #1;
            chk("idle.busy", DATA_W'(busy_o), 0);
            chk("idle.valid", DATA_W'(dump_valid_o), 0);
        end

        run_dump(0);
        run_dump(1);
        run_dump(2);
        repeat (3) @(posedge clk_i);
        run_dump(4);
        repeat (2) @(posedge clk_i);
        run_dump(3);
        run_dump(0);

        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
